// File: rtl/regfile_mp.sv
// regfile_mp -- parametrised multi-read-port integer register file with a
// hardware clear sequencer and a per-register pending scoreboard.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : a write in the current cycle is forwarded combinationally to
//               any read port addressing the same register.
//   undefined : reads return the stored value and stored pending bit only.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset; starts a full clear sequence
//   rs_addr    NRD packed read addresses, port k at [k*AW +: AW]
//   rd_data    NRD packed read data, port k at [k*XLEN +: XLEN]
//   rs_pend    per-port "result outstanding" flag
//   wr_en      writeback write enable
//   wr_addr    writeback register address
//   wr_data    writeback data
//   pend_set   mark pend_addr as outstanding (issue)
//   pend_addr  register to mark outstanding
//   clr_req    software request to zero the whole file
//   busy       clear sequence in progress (reads return 0, writes are lost)
module regfile_mp #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rs_pend,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                pend_set,
    input  logic [AW-1:0]       pend_addr,
    input  logic                clr_req,
    output logic                busy
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t            state_reg;
    logic [AW-1:0]     idx_reg;
    logic [NREGS-1:0]  pend_reg;
    logic [XLEN-1:0]   regs_mem [NREGS];

    // Accepted writeback: only in IDLE, not to x0, and not in a cycle that
    // also accepts a clear request.
    logic wb_accept;
    assign wb_accept = (state_reg == ST_IDLE) && !clr_req && wr_en && (wr_addr != '0);

    // Reset is folded in so busy is high even before the first reset edge
    // has moved the state machine into CLEAR.
    assign busy = reset || (state_reg == ST_CLEAR);

    // Sequencer and scoreboard.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_CLEAR;
            idx_reg   <= '0;
            pend_reg  <= '0;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    idx_reg <= idx_reg + 1'b1;
                    if (idx_reg == AW'(NREGS - 1)) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    if (clr_req) begin
                        state_reg <= ST_CLEAR;
                        idx_reg   <= '0;
                        pend_reg  <= '0;
                    end else begin
                        if (wb_accept) begin
                            pend_reg[wr_addr] <= 1'b0;
                        end
                        // Issue of a new producer overrides the completing
                        // write of an older one to the same register.
                        if (pend_set && (pend_addr != '0)) begin
                            pend_reg[pend_addr] <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Storage: a single write port shared by the clear sequencer and
    // writeback. x0 is only ever written with zero by the clear sequence.
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [XLEN-1:0] mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (!reset) begin
            if (state_reg == ST_CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = idx_reg;
                mem_wdata = '0;
            end else if (wb_accept) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            regs_mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read ports, fully independent of each other.
    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0] addr;
            logic          fwd;
            assign addr = rs_addr[gi*AW +: AW];
`ifdef REGFILE_BYPASS_EN
            assign fwd = wr_en && !busy && (wr_addr != '0) && (wr_addr == addr);
`else
            assign fwd = 1'b0;
`endif
            always_comb begin
                rd_data[gi*XLEN +: XLEN] = '0;
                rs_pend[gi]              = 1'b0;
                if (!busy && (addr != '0)) begin
                    if (fwd) begin
                        rd_data[gi*XLEN +: XLEN] = wr_data;
                        rs_pend[gi]              = pend_set && (pend_addr == addr);
                    end else begin
                        rd_data[gi*XLEN +: XLEN] = regs_mem[addr];
                        rs_pend[gi]              = pend_reg[addr];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios followed by random
// traffic, all compared against a behavioural model of the register file.
module tb_regfile_mp;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = $clog2(NREGS);

    logic                clk = 1'b0;
    logic                reset;
    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rs_pend;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                pend_set;
    logic [AW-1:0]       pend_addr;
    logic                clr_req;
    logic                busy;

    int checks = 0;
    int errors = 0;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk       (clk),
        .reset     (reset),
        .rs_addr   (rs_addr),
        .rd_data   (rd_data),
        .rs_pend   (rs_pend),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .pend_set  (pend_set),
        .pend_addr (pend_addr),
        .clr_req   (clr_req),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: a clear zeroes everything at once and then hides the
    // file for NREGS cycles.
    logic [XLEN-1:0] m_regs [NREGS];
    logic            m_pend [NREGS];
    int              m_busy_left = 0;
    logic            last_busy;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_zero();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            m_busy_left = NREGS;
            model_zero();
        end else if (m_busy_left > 0) begin
            m_busy_left--;
        end else if (clr_req) begin
            m_busy_left = NREGS;
            model_zero();
        end else begin
            if (wr_en && wr_addr != 0) begin
                m_regs[wr_addr] = wr_data;
                m_pend[wr_addr] = 1'b0;
            end
            if (pend_set && pend_addr != 0) m_pend[pend_addr] = 1'b1;
        end
    endtask

    task automatic check_outputs();
        logic            exp_busy;
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        logic            p;
        exp_busy = reset || (m_busy_left > 0);
        check("busy", XLEN'(busy), XLEN'(exp_busy));
        for (int k = 0; k < NRD; k++) begin
            a = rs_addr[k*AW +: AW];
            d = '0;
            p = 1'b0;
            if (!exp_busy && a != 0) begin
                d = m_regs[a];
                p = m_pend[a];
`ifdef REGFILE_BYPASS_EN
                if (wr_en && wr_addr != 0 && wr_addr == a) begin
                    d = wr_data;
                    p = pend_set && (pend_addr == a);
                end
`endif
            end
            check($sformatf("rd_data%0d", k), rd_data[k*XLEN +: XLEN], d);
            check($sformatf("rs_pend%0d", k), XLEN'(rs_pend[k]), XLEN'(p));
        end
    endtask

    // One transaction: inputs were set just after an edge; check the settled
    // outputs, then let the edge happen and advance the model.
    task automatic step();
        #3;
        check_outputs();
        last_busy = busy;
        $display("t=%0t rst=%b we=%b wa=%0d wd=%h ps=%b pa=%0d clr=%b rs=%h | busy=%b rd=%h pend=%b",
                 $time, reset, wr_en, wr_addr, wr_data, pend_set, pend_addr, clr_req,
                 rs_addr, busy, rd_data, rs_pend);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
        pend_set = 0; pend_addr = '0; clr_req = 0; rs_addr = '0;
    endtask

    task automatic random_inputs();
        wr_en     = ($urandom % 2) == 0;
        wr_addr   = AW'($urandom);
        wr_data   = XLEN'({$urandom, $urandom});
        pend_set  = ($urandom % 3) == 0;
        pend_addr = (($urandom % 3) == 0) ? wr_addr : AW'($urandom);
        for (int k = 0; k < NRD; k++)
            rs_addr[k*AW +: AW] = (($urandom % 4) == 0) ? wr_addr : AW'($urandom);
        clr_req   = ($urandom % 80) == 0;
        reset     = ($urandom % 250) == 0;
    endtask

    // Count cycles with busy high after a clear has begun; random writes and
    // pend_sets are thrown at the block meanwhile and must be lost.
    task automatic measure_busy(input string tag);
        int n = 0;
        for (int i = 0; i < 4 * NREGS; i++) begin
            random_inputs();
            reset = 0;
            clr_req = 0;
            step();
            if (!last_busy) break;
            n++;
        end
        check(tag, XLEN'(n), XLEN'(NREGS));
    endtask

    task automatic read_all();
        idle_inputs();
        for (int a = 0; a < NREGS; a++) begin
            for (int k = 0; k < NRD; k++) rs_addr[k*AW +: AW] = AW'(a);
            step();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        reset = 1;
        #1;
        check("busy_in_reset", XLEN'(busy), XLEN'(1));
        @(posedge clk);
        #1;
        // Reset sequence
        for (int i = 0; i < 3; i++) step();
        reset = 0;
        measure_busy("clr_len_reset");
        read_all();

        // Write/read and x0 behaviour
        idle_inputs();
        wr_en = 1; wr_addr = 5; wr_data = XLEN'(32'hDEADBEEF);
        rs_addr[0 +: AW] = 5;
        step();
        wr_en = 0;
        #1;
        check("x5_readback", rd_data[0 +: XLEN], XLEN'(32'hDEADBEEF));
        step();
        wr_en = 1; wr_addr = 0; wr_data = XLEN'(32'h1234); rs_addr = '0;
        step();
        wr_en = 0;
        step();

        // Same-cycle write to a read register
        wr_en = 1; wr_addr = 7; wr_data = XLEN'(8'h55); rs_addr[0 +: AW] = 7;
        step();
        wr_en = 0;
        step();

        // Scoreboard
        idle_inputs();
        rs_addr[0 +: AW] = 9;
        pend_set = 1; pend_addr = 9;
        step();
        pend_set = 0;
        step();
        wr_en = 1; wr_addr = 9; wr_data = XLEN'(32'h99);
        step();
        wr_en = 0;
        step();
        pend_set = 1; wr_en = 1; wr_data = XLEN'(32'h98);
        step();
        pend_set = 0; wr_en = 0;
        #1;
        check("pend_set_wins", XLEN'(rs_pend[0]), XLEN'(1));
        step();

        // Software clear after filling the file
        idle_inputs();
        for (int a = 1; a < NREGS; a++) begin
            wr_en = 1; wr_addr = AW'(a); wr_data = XLEN'(32'hA000_0000 + a);
            rs_addr[0 +: AW] = AW'(a);
            step();
        end
        idle_inputs();
        clr_req = 1;
        step();
        measure_busy("clr_len_sw");
        read_all();

        // Reset part-way through a clear
        idle_inputs();
        clr_req = 1;
        step();
        clr_req = 0;
        for (int i = 0; i < 10; i++) step();
        reset = 1;
        step();
        step();
        reset = 0;
        measure_busy("clr_len_restart");
        read_all();

        // Random traffic
        for (int i = 0; i < 700; i++) begin
            random_inputs();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
